// File: rtl/button_pkg.sv
// ----------------------------------------------------------------------------
// button_pkg : shared debounce FSM encoding and event polarity constants
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package button_pkg;

  typedef logic [1:0] btn_state_t;

  localparam btn_state_t IDLE         = 2'd0;
  localparam btn_state_t PRESS_WAIT   = 2'd1;
  localparam btn_state_t HELD         = 2'd2;
  localparam btn_state_t RELEASE_WAIT = 2'd3;

  localparam logic EVT_RELEASE = 1'b0;
  localparam logic EVT_PRESS   = 1'b1;

  // Width of a button index; a single button still needs one code bit.
  function automatic int btn_code_w(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce : one button channel - 2-flop sync, debounce FSM, optional
//                auto-repeat (BTN_REPEAT_EN)
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module btn_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]   C_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  btn_state_t    r_state;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // The accepting edge counts as the last stable sample, so compare with D-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= C_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!r_sync2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state     <= HELD;
            r_cnt       <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        HELD: begin
          if (!r_sync2) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= C_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (r_sync2) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == C_LAST) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + C_ONE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int              RCW     = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RCW-1:0]  C_RLAST = RCW'(REPEAT_CYCLES - 1);

  logic [RCW-1:0] r_rcnt;

  // Counts only while settled in HELD; any excursion restarts the period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rcnt       <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (r_state == HELD && r_sync2) begin
        if (r_rcnt == C_RLAST) begin
          r_rcnt       <= '0;
          repeat_pulse <= 1'b1;
        end else begin
          r_rcnt <= r_rcnt + RCW'(1);
        end
      end else begin
        r_rcnt <= '0;
      end
    end
  end
`else
  logic w_unused_repeat;
  assign w_unused_repeat = (REPEAT_CYCLES > 0);
  assign repeat_pulse    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/button_reader.sv
// ----------------------------------------------------------------------------
// button_reader : N debounced buttons with press/release pulses and a
//                 1-entry valid/ready event buffer (repeat via BTN_REPEAT_EN)
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module button_reader
  import button_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_CYCLES   = 500000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BTN-1:0]             btn_raw,
  output logic [N_BTN-1:0]             btn_level,
  output logic [N_BTN-1:0]             press_pulse,
  output logic [N_BTN-1:0]             release_pulse,
  output logic                         evt_valid,
  output logic [btn_code_w(N_BTN)-1:0] evt_code,
  output logic                         evt_press,
  input  logic                         evt_ready,
  output logic                         evt_overflow
);

  localparam int CODE_W = btn_code_w(N_BTN);

  logic [N_BTN-1:0]  w_repeat;
  logic [N_BTN-1:0]  w_fire;
  logic              w_any;
  logic              w_multi;
  logic [CODE_W-1:0] w_idx;
  logic              w_idx_press;
  logic              w_can_load;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_debounce (
        .clk           (clk),
        .rst           (rst),
        .raw           (btn_raw[i]),
        .level         (btn_level[i]),
        .press_pulse   (press_pulse[i]),
        .release_pulse (release_pulse[i]),
        .repeat_pulse  (w_repeat[i])
      );
    end
  endgenerate

  assign w_fire  = press_pulse | release_pulse | w_repeat;
  assign w_any   = |w_fire;
  assign w_multi = |(w_fire & (w_fire - N_BTN'(1)));

  // Scan downwards so the lowest firing index wins.
  always_comb begin
    w_idx       = '0;
    w_idx_press = EVT_RELEASE;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_fire[i]) begin
        w_idx       = CODE_W'(i);
        w_idx_press = (press_pulse[i] | w_repeat[i]) ? EVT_PRESS : EVT_RELEASE;
      end
    end
  end

  assign w_can_load = !evt_valid || evt_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid    <= 1'b0;
      evt_code     <= '0;
      evt_press    <= 1'b0;
      evt_overflow <= 1'b0;
    end else begin
      evt_overflow <= w_any && (!w_can_load || w_multi);
      if (w_any && w_can_load) begin
        evt_valid <= 1'b1;
        evt_code  <= w_idx;
        evt_press <= w_idx_press;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_reader.sv
// ----------------------------------------------------------------------------
// tb_button_reader : directed and random checks of button_reader against a
//                    run-length reference model
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_button_reader;

  localparam int N = 4;
  localparam int D = 4;
  localparam int R = 20;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic [3:0] btn_raw   = 4'h0;
  logic       evt_ready = 1'b0;
  logic [3:0] btn_level, press_pulse, release_pulse;
  logic       evt_valid, evt_press, evt_overflow;
  logic [1:0] evt_code;

  int tests = 0;
  int fails = 0;

  button_reader #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .evt_valid     (evt_valid),
    .evt_code      (evt_code),
    .evt_press     (evt_press),
    .evt_ready     (evt_ready),
    .evt_overflow  (evt_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: raw delayed two samples, level flips after D
  // consecutive samples disagreeing with it.
  logic [3:0] m_d1, m_d2, m_level, m_press, m_rel, m_rep;
  int         m_run [N];
  int         m_rrun[N];
  logic       m_valid, m_evp, m_ovf;
  logic [1:0] m_code;

  function automatic logic [18:0] dut_vec();
    return {btn_level, press_pulse, release_pulse, evt_valid, evt_code, evt_press, evt_overflow};
  endfunction

  function automatic logic [18:0] mod_vec();
    return {m_level, m_press, m_rel, m_valid, m_code, m_evp, m_ovf};
  endfunction

  task automatic mreset();
    m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
    m_valid = 1'b0; m_evp = 1'b0; m_ovf = 1'b0; m_code = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i]  = 0;
      m_rrun[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] fire;
    int         nfire;
    int         idx;
    logic       pop, was_valid, s;
    fire      = m_press | m_rel | m_rep;
    nfire     = $countones(fire);
    was_valid = m_valid;
    pop       = m_valid && evt_ready;
    m_ovf     = (nfire > 0) && ((was_valid && !pop) || nfire > 1);
    if (pop) m_valid = 1'b0;
    if (nfire > 0 && (!was_valid || pop)) begin
      idx = 0;
      for (int i = N - 1; i >= 0; i--) if (fire[i]) idx = i;
      m_valid = 1'b1;
      m_code  = 2'(idx);
      m_evp   = m_press[idx] | m_rep[idx];
    end
    for (int i = 0; i < N; i++) begin
      s          = m_d2[i];
      m_press[i] = 1'b0;
      m_rel[i]   = 1'b0;
      m_rep[i]   = 1'b0;
`ifdef BTN_REPEAT_EN
      if (m_level[i] && m_run[i] == 0 && s) begin
        m_rrun[i]++;
        if (m_rrun[i] == R) begin
          m_rep[i]  = 1'b1;
          m_rrun[i] = 0;
        end
      end else begin
        m_rrun[i] = 0;
      end
`endif
      if (s != m_level[i]) m_run[i]++;
      else                 m_run[i] = 0;
      if (m_run[i] == D) begin
        m_level[i] = ~m_level[i];
        m_run[i]   = 0;
        if (m_level[i]) m_press[i] = 1'b1;
        else            m_rel[i]   = 1'b1;
      end
    end
    m_d2 = m_d1;
    m_d1 = btn_raw;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) mreset();
    else      model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_raw = 4'hF; evt_ready = 1'b0;
    repeat (3) tick();
    tests++;
    if (dut_vec() !== 19'd0) begin
      fails++; $display("FAIL reset_hold: got %h expected 0", dut_vec());
    end
    rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL reset_model cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
      if (k < 6) begin
        tests++;
        if (dut_vec() !== 19'd0) begin
          fails++; $display("FAIL reset_quiet cyc %0d: got %h expected 0", k, dut_vec());
        end
      end
      if (k == 6) begin
        tests++;
        if (press_pulse !== 4'hF || btn_level !== 4'hF) begin
          fails++; $display("FAIL reset_press: got pulse %h level %h expected F F", press_pulse, btn_level);
        end
      end
      if (k == 7) begin
        tests++;
        if ({evt_valid, evt_code, evt_press, evt_overflow} !== 5'b1_00_1_1) begin
          fails++; $display("FAIL reset_event: got %b expected 10011", {evt_valid, evt_code, evt_press, evt_overflow});
        end
      end
      if (k == 8) begin
        tests++;
        if (evt_overflow !== 1'b0 || evt_valid !== 1'b1 || evt_code !== 2'd0) begin
          fails++; $display("FAIL reset_ovf_once: got ovf %b valid %b code %0d expected 0 1 0", evt_overflow, evt_valid, evt_code);
        end
      end
    end
    evt_ready = 1'b1; btn_raw = 4'h0;
    for (int k = 0; k < 15; k++) begin
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL reset_settle cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    evt_ready = 1'b1; btn_raw = 4'b0100;
    for (int k = 1; k <= 30; k++) begin
      if (k == 11) btn_raw = 4'h0;
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL clean_model cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
      if (k == 5) begin
        tests++;
        if (btn_level[2] !== 1'b0) begin
          fails++; $display("FAIL clean_early: got level %b expected 0", btn_level[2]);
        end
      end
      if (k == 6) begin
        tests++;
        if (btn_level[2] !== 1'b1 || press_pulse !== 4'b0100) begin
          fails++; $display("FAIL clean_press: got level %b pulse %h expected 1 4", btn_level[2], press_pulse);
        end
      end
      if (k == 7) begin
        tests++;
        if ({evt_valid, evt_code, evt_press} !== 4'b1_10_1) begin
          fails++; $display("FAIL clean_event: got %b expected 1101", {evt_valid, evt_code, evt_press});
        end
      end
      if (k == 8) begin
        tests++;
        if (evt_valid !== 1'b0) begin
          fails++; $display("FAIL clean_pop: got valid %b expected 0", evt_valid);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat;
    pat = 5'b01101;
    for (int k = 0; k < 15; k++) begin
      btn_raw[1] = (k < 5) ? pat[k] : 1'b0;
      tick();
      tests++;
      if ({btn_level, press_pulse, release_pulse, evt_valid, evt_overflow} !== 14'd0 ||
          dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL bounce cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    evt_ready = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 1)  btn_raw[0] = 1'b1;
      if (k == 11) btn_raw[3] = 1'b1;
      if (k == 23) evt_ready = 1'b1;
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL bp_model cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
      if (k >= 7 && k <= 22) begin
        tests++;
        if ({evt_valid, evt_code, evt_press} !== 4'b1_00_1) begin
          fails++; $display("FAIL bp_stable cyc %0d: got %b expected 1001", k, {evt_valid, evt_code, evt_press});
        end
      end
      if (k == 16 || k == 17 || k == 18) begin
        tests++;
        if (evt_overflow !== (k == 17)) begin
          fails++; $display("FAIL bp_overflow cyc %0d: got %b expected %b", k, evt_overflow, (k == 17));
        end
      end
      if (k >= 23) begin
        tests++;
        if (evt_valid !== 1'b0) begin
          fails++; $display("FAIL bp_pop cyc %0d: got valid %b expected 0", k, evt_valid);
        end
      end
    end
    btn_raw = 4'h0;
    for (int k = 0; k < 15; k++) begin
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL bp_release cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    evt_ready = 1'b1; btn_raw = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL b2b_setup cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
    end
    evt_ready = 1'b0; btn_raw = 4'b0101;
    repeat (10) tick();
    tests++;
    if ({evt_valid, evt_code, evt_press} !== 4'b1_00_1) begin
      fails++; $display("FAIL b2b_buffered: got %b expected 1001", {evt_valid, evt_code, evt_press});
    end
    btn_raw = 4'b0001;
    repeat (6) tick();
    tests++;
    if (release_pulse !== 4'b0100 || dut_vec() !== mod_vec()) begin
      fails++; $display("FAIL b2b_release: got pulse %h expected 4", release_pulse);
    end
    evt_ready = 1'b1;
    tick();
    tests++;
    if ({evt_valid, evt_code, evt_press, evt_overflow} !== 5'b1_10_0_0) begin
      fails++; $display("FAIL b2b_reload: got %b expected 11000", {evt_valid, evt_code, evt_press, evt_overflow});
    end
    tick();
    tests++;
    if (evt_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain: got valid %b expected 0", evt_valid);
    end
    btn_raw = 4'h0;
    for (int k = 0; k < 15; k++) begin
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL b2b_settle cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
    end
  endtask

  task automatic test_repeat();
    logic [2:0] ev_q[$];
    int         exp_n;
    evt_ready = 1'b1;
`ifdef BTN_REPEAT_EN
    exp_n = 5;
`else
    exp_n = 2;
`endif
    for (int k = 1; k <= 100; k++) begin
      btn_raw[1] = (k <= 70);
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL repeat_model cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
      if (evt_valid) ev_q.push_back({evt_code, evt_press});
    end
    tests++;
    if (ev_q.size() != exp_n) begin
      fails++; $display("FAIL repeat_count: got %0d expected %0d", ev_q.size(), exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        tests++;
        if (ev_q[i] !== {2'd1, (i != exp_n - 1)}) begin
          fails++; $display("FAIL repeat_event %0d: got %b expected %b", i, ev_q[i], {2'd1, (i != exp_n - 1)});
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) btn_raw[i] = ~btn_raw[i];
      evt_ready = ($urandom_range(0, 3) != 0);
      if (k == 300) begin
        rst = 1'b0;
        #1;
        tests++;
        if (dut_vec() !== 19'd0) begin
          fails++; $display("FAIL async_reset: got %h expected 0", dut_vec());
        end
        mreset();
        repeat (2) tick();
        rst = 1'b1;
      end
      tick();
      tests++;
      if (dut_vec() !== mod_vec()) begin
        fails++; $display("FAIL random cyc %0d: got %h expected %h", k, dut_vec(), mod_vec());
      end
    end
  endtask

  initial begin
    mreset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_backpressure();
    test_back_to_back();
    test_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
